spi_tx_feeder: RTL

Byte-pacing stage placed directly upstream of the SPI master's parallel transmit input. It accepts bytes from the host side over a valid/ready handshake and buffers them in a small FIFO. It then presents them one at a time on `BUS_IN` with the `Data_Available` hold/gap strobe protocol the SPI master consumes. It also counts bytes into fixed-length frames and flags each completed frame.

---
 rtl/spi_tx_pkg.sv | 25 ++
 rtl/spi_tx_feeder_byte_fifo.sv | 83 ++++++++
 rtl/spi_tx_feeder.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/spi_tx_pkg.sv
// Shared types and default constants for the SPI transmit feeder.
package spi_tx_pkg;

  // Strobe sequencer states: wait for data, present a byte, enforce the gap.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Mclk cycles Data_Available stays high per byte.
  localparam int DEF_HOLD_CYCLES = 256;
  // Minimum Mclk cycles Data_Available stays low between bytes.
  localparam int DEF_GAP_CYCLES  = 256;
  // Bytes per SPI frame (120-bit payload).
  localparam int DEF_FRAME_BYTES = 15;
  // FIFO depth in bytes (power of two, at least 2).
  localparam int DEF_DEPTH       = 16;

  // Larger of two integers, used to size the shared hold/gap timer.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_tx_feeder_byte_fifo.sv
// Parameterised synchronous FIFO: circular buffer with wrapping pointers,
// registered full/empty flags and an occupancy count of 0..DEPTH.
module byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  // Clear wins over both push and pop; full/empty gate the handshake.
  assign do_push = push && !full_q && !clear;
  assign do_pop  = pop && !empty_q && !clear;

  // Next pointer/level; power-of-two depth lets the pointers wrap naturally.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      level_d = level_q + LW'(1);
      else if (!do_push && do_pop) level_d = level_q - LW'(1);
    end
    full_d  = (level_d == LW'(DEPTH));
    empty_d = (level_d == '0);
  end

  // Pointer, level and flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; the level/flags mark which entries are valid.
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem[rd_ptr_q];
  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = level_q;

endmodule

// File: rtl/spi_tx_feeder.sv
// Byte-pacing stage in front of the SPI master: buffers host bytes and
// presents them one at a time on BUS_IN with a fixed hold/gap strobe,
// counting bytes into frames and pulsing Frame_Done per completed frame.
module spi_tx_feeder
  import spi_tx_pkg::*;
#(
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int FRAME_BYTES = DEF_FRAME_BYTES
) (
  input  logic                           Mclk,
  input  logic                           Reset,
  input  logic [7:0]                     Host_Data,
  input  logic                           Host_Valid,
  output logic                           Host_Ready,
  input  logic                           Flush,
  output logic [7:0]                     BUS_IN,
  output logic                           Data_Available,
  output logic                           Busy,
  output logic                           Frame_Done,
  output logic [$clog2(FRAME_BYTES)-1:0] Byte_Count,
  output logic [$clog2(DEPTH):0]         Fifo_Level
);

  localparam int MAX_CYC = max_int(HOLD_CYCLES, GAP_CYCLES);
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  // The internal byte counter must be able to hold FRAME_BYTES itself.
  localparam int BCW     = $clog2(FRAME_BYTES + 1);
  localparam int BW      = $clog2(FRAME_BYTES);

  localparam logic [TW-1:0]  HOLD_LOAD  = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0]  GAP_LOAD   = TW'(GAP_CYCLES - 1);
  localparam logic [BCW-1:0] FRAME_LAST = BCW'(FRAME_BYTES);

  state_e         state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [7:0]     bus_in_q, bus_in_d;
  logic           da_q, da_d;
  logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
  logic           frame_done_q, frame_done_d;

  logic           fifo_pop;
  logic [7:0]     fifo_dout;
  logic           fifo_full;
  logic           fifo_empty;
  logic           can_pop;

  // Byte buffer between host handshake and the strobe sequencer.
  byte_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (Mclk),
    .rst       (Reset),
    .clear     (Flush),
    .push      (Host_Valid),
    .push_data (Host_Data),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (Fifo_Level)
  );

  // A flush empties the FIFO this edge, so nothing may be popped alongside it.
  assign can_pop = !fifo_empty && !Flush;

  // Next-state logic: IDLE -> HOLD (pop) -> GAP -> HOLD or IDLE.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    bus_in_d     = bus_in_q;
    da_d         = da_q;
    byte_cnt_d   = byte_cnt_q;
    frame_done_d = 1'b0;
    fifo_pop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (can_pop) begin
          fifo_pop = 1'b1;
          bus_in_d = fifo_dout;
          da_d     = 1'b1;
          timer_d  = HOLD_LOAD;
          state_d  = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (Flush) begin
          // Truncate the strobe but still guarantee a full legal gap after it.
          da_d    = 1'b0;
          timer_d = GAP_LOAD;
          state_d = ST_GAP;
        end else if (timer_q == '0) begin
          da_d       = 1'b0;
          byte_cnt_d = byte_cnt_q + BCW'(1);
          timer_d    = GAP_LOAD;
          state_d    = ST_GAP;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      ST_GAP: begin
        if (timer_q == '0) begin
          if (byte_cnt_q == FRAME_LAST) begin
            frame_done_d = 1'b1;
            byte_cnt_d   = '0;
          end
          if (can_pop) begin
            // Chain straight into the next byte with no idle cycle.
            fifo_pop = 1'b1;
            bus_in_d = fifo_dout;
            da_d     = 1'b1;
            timer_d  = HOLD_LOAD;
            state_d  = ST_HOLD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        da_d    = 1'b0;
      end
    endcase

    // Flush discards the partial frame and never reports it as done.
    if (Flush) begin
      byte_cnt_d   = '0;
      frame_done_d = 1'b0;
    end
  end

  // Sequencer registers with synchronous active-high reset.
  always_ff @(posedge Mclk) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      bus_in_q     <= '0;
      da_q         <= 1'b0;
      byte_cnt_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      bus_in_q     <= bus_in_d;
      da_q         <= da_d;
      byte_cnt_q   <= byte_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Full flag is registered inside the FIFO, so ready drops the cycle after the filling push.
  assign Host_Ready     = !fifo_full;
  assign BUS_IN         = bus_in_q;
  assign Data_Available = da_q;
  assign Frame_Done     = frame_done_q;
  assign Byte_Count     = byte_cnt_q[BW-1:0];
  assign Busy           = (state_q != ST_IDLE) || !fifo_empty;

endmodule
